// File: rtl/mips_multicycle_ctrl.sv
// Control sequencer for the shared multicycle MIPS datapath: walks each instruction
// through fetch/decode/execute/writeback, counts retired instructions, flags bad encodings.
module mips_multicycle_ctrl #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 iord,
   output logic                 memwrite,
   output logic                 irwrite,
   output logic                 pcen,
   output logic [1:0]           pcsrc,
   output logic                 alusrca,
   output logic [1:0]           alusrcb,
   output logic [2:0]           alucont,
   output logic                 signext,
   output logic                 shiftl16,
   output logic                 regdst,
   output logic                 memtoreg,
   output logic                 regwrite,
   output logic                 illegal,
   output logic [3:0]           state,
   output logic [CNT_WIDTH-1:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
      S_MEMWB = 4'd4, S_MEMWR = 4'd5, S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
      S_BREX = 4'd8, S_IEX = 4'd9, S_IWB = 4'd10, S_JEX = 4'd11
   } state_t;

   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
   localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001, F_SUB = 6'b100010;
   localparam logic [5:0] F_SUBU = 6'b100011, F_AND = 6'b100100, F_OR = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   state_t                state_r;
   state_t                next_s;
   logic [CNT_WIDTH-1:0]  instret_r;
   logic                  retire_s;
   logic                  rtype_ok_s;
   logic                  mem_req_s, memwrite_s, irwrite_s, pcen_s, regwrite_s, illegal_s;

   // Supported R-type function codes
   always_comb begin
      case (funct)
         F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_SLT: rtype_ok_s = 1'b1;
         default:                                          rtype_ok_s = 1'b0;
      endcase
   end

   // Next state, datapath controls and retire strobe for the current state
   always_comb begin
      next_s     = S_FETCH;
      retire_s   = 1'b0;
      mem_req_s  = 1'b0;
      iord       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      pcen_s     = 1'b0;
      pcsrc      = 2'b00;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      alucont    = 3'b000;
      signext    = 1'b0;
      shiftl16   = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      illegal_s  = 1'b0;
      case (state_r)
         S_FETCH: begin
            mem_req_s = 1'b1;
            alusrcb   = 2'b01;
            alucont   = 3'b010;
            irwrite_s = mem_ready;
            pcen_s    = mem_ready;
            next_s    = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            alucont = 3'b010;
            signext = 1'b1;
            case (op)
               OP_LW, OP_SW:   next_s = S_MEMADR;
               OP_R: begin
                  if (rtype_ok_s) begin
                     next_s = S_RTYPEEX;
                  end else begin
                     next_s    = S_FETCH;
                     illegal_s = 1'b1;
                  end
               end
               OP_BEQ, OP_BNE: next_s = S_BREX;
               OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: next_s = S_IEX;
               OP_J:           next_s = S_JEX;
               default: begin
                  next_s    = S_FETCH;
                  illegal_s = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            alucont = 3'b010;
            signext = 1'b1;
            next_s  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_req_s = 1'b1;
            iord      = 1'b1;
            next_s    = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg   = 1'b1;
            retire_s   = 1'b1;
         end
         S_MEMWR: begin
            mem_req_s  = 1'b1;
            iord       = 1'b1;
            memwrite_s = 1'b1;
            retire_s   = mem_ready;
            next_s     = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            next_s  = S_RTYPEWB;
            case (funct)
               F_SUB, F_SUBU: alucont = 3'b110;
               F_AND:         alucont = 3'b000;
               F_OR:          alucont = 3'b001;
               F_SLT:         alucont = 3'b111;
               default:       alucont = 3'b010;
            endcase
         end
         S_RTYPEWB: begin
            regwrite_s = 1'b1;
            regdst     = 1'b1;
            retire_s   = 1'b1;
         end
         S_BREX: begin
            alusrca  = 1'b1;
            alucont  = 3'b110;
            pcsrc    = 2'b01;
            pcen_s   = (op == OP_BNE) ? ~zero : zero;
            retire_s = 1'b1;
         end
         S_IEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            next_s  = S_IWB;
            case (op)
               OP_SLTI: begin
                  alucont = 3'b111;
                  signext = 1'b1;
               end
               OP_ANDI: alucont = 3'b000;
               OP_ORI:  alucont = 3'b001;
               OP_LUI: begin
                  alucont  = 3'b001;
                  shiftl16 = 1'b1;
               end
               default: begin
                  alucont = 3'b010;
                  signext = 1'b1;
               end
            endcase
         end
         S_IWB: begin
            regwrite_s = 1'b1;
            retire_s   = 1'b1;
         end
         S_JEX: begin
            pcsrc    = 2'b10;
            pcen_s   = 1'b1;
            retire_s = 1'b1;
         end
         default: next_s = S_FETCH;
      endcase
   end

   // Side-effecting strobes are held off while reset is asserted
   assign mem_req  = mem_req_s & reset;
   assign memwrite = memwrite_s & reset;
   assign irwrite  = irwrite_s & reset;
   assign pcen     = pcen_s & reset;
   assign regwrite = regwrite_s & reset;
   assign illegal  = illegal_s & reset;
   assign state    = state_r;
   assign instret  = instret_r;

   // State register and retired-instruction counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= S_FETCH;
         instret_r <= '0;
      end else begin
         state_r <= next_s;
         if (retire_s) begin
            instret_r <= instret_r + CNT_WIDTH'(1);
         end else begin
            instret_r <= instret_r;
         end
      end
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control FSM that sequences the shared multicycle MIPS datapath. It drives a single ALU, register file, sign/zero extender, shift-left-16 unit, instruction/address muxes and the PC enable flop, one instruction at a time, over 3–5+ cycles. Instruction and data memory share one port with a ready handshake. The block also counts retired instructions and flags illegal encodings.

## Interface
- CNT_WIDTH, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  6  opcode from instruction register (IR[31:26])
- funct  in  6  function field from IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access requested
- iord  out  1  address mux: 0=PC, 1=ALUOut
- memwrite  out  1  memory write request
- irwrite  out  1  load IR
- pcen  out  1  PC flop enable
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alusrca  out  1  0=PC, 1=rs
- alusrcb  out  2  00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
- alucont  out  3  [2]=invert b + carry-in; [1:0] 00 and, 01 or, 10 sum, 11 slt
- signext  out  1  1=sign-extend imm, 0=zero-extend
- shiftl16  out  1  immediate shifted left 16 (lui)
- regdst  out  1  0=rt, 1=rd
- memtoreg  out  1  0=ALUOut, 1=memory data
- regwrite  out  1  register file write enable
- illegal  out  1  one-cycle pulse, unsupported encoding
- state  out  4  current state (debug)
- instret  out  CNT_WIDTH  retired-instruction count

## Operation
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BREX=8, IEX=9, IWB=10, JEX=11. Codes 12–15 go to FETCH.
- Default for every output: 0. Listed signals override the default.
- FETCH
  - mem_req=1, iord=0, alusrca=0, alusrcb=01, alucont=010, pcsrc=00.
  - irwrite=pcen=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE
  - alusrca=0, alusrcb=11, alucont=010, signext=1 (branch target into ALUOut).
  - Next state by op:
    - lw 100011, sw 101011 → MEMADR
    - R-type 000000 → RTYPEEX
    - beq 000100, bne 000101 → BREX
    - addi 001000, addiu 001001, slti 001010, andi 001100, ori 001101, lui 001111 → IEX
    - j 000010 → JEX
    - other op, or R-type with funct not in {add 100000, addu 100001, sub 100010, subu 100011, and 100100, or 100101, slt 101010} → FETCH with illegal=1
- MEMADR: alusrca=1, alusrcb=10, alucont=010, signext=1. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_req=1, iord=1. Held until mem_ready, then MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. Then FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. Held until mem_ready, then FETCH.
- RTYPEEX
  - alusrca=1, alusrcb=00.
  - alucont: add/addu 010, sub/subu 110, and 000, or 001, slt 111.
  - Then RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Then FETCH.
- BREX: alusrca=1, alusrcb=00, alucont=110, pcsrc=01. pcen=zero (beq) or ~zero (bne). Then FETCH.
- IEX
  - alusrca=1, alusrcb=10.
  - addi/addiu: alucont=010, signext=1.
  - slti: alucont=111, signext=1.
  - andi: alucont=000, signext=0.
  - ori: alucont=001, signext=0.
  - lui: alucont=001, signext=0, shiftl16=1.
  - Then IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0. Then FETCH.
- JEX: pcsrc=10, pcen=1. Then FETCH.
- instret increments by 1 on the last cycle of each legal instruction:
  - MEMWB, RTYPEWB, BREX, IWB, JEX
  - MEMWR when mem_ready=1
- instret wraps modulo 2^CNT_WIDTH. Illegal instructions do not count.

## Timing
- state and instret are registered; all other outputs are combinational from state, op, funct, zero and mem_ready.
- Reset low: state=FETCH and instret=0 immediately.
  - While reset is low, mem_req, memwrite, irwrite, pcen, regwrite and illegal are forced to 0.
  - Other outputs keep their FETCH values.
- First FETCH with mem_req=1 is the first clk edge after reset deasserts.
- Reset asserted mid-instruction aborts it: no further write enables, and no instret increment.
- Cycles per instruction with mem_ready constantly 1:
  - 3: beq, bne, j
  - 4: R-type, I-type, sw
  - 5: lw
  - illegal: 2 (FETCH, DECODE)
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Write enables are active for exactly one cycle per instruction, except memwrite, which is held until mem_ready.

## Test plan
- reset low during MEMRD → state=0, instret=0, all write enables 0. Release → mem_req=1 on the next cycle, instret stays 0.
- add (op=000000, funct=100000), mem_ready=1 → states 0,1,6,7,0. alucont=010 in state 6. regwrite=1 and regdst=1 only in state 7. instret goes 0→1.
- lw with mem_ready=0 for 3 cycles in MEMRD → state 3 held for 4 cycles with mem_req=1 and iord=1. Then state 4 with regwrite=1, memtoreg=1. 5+3 total cycles.
- beq with zero=1 → pcen=1, pcsrc=01 in BREX. bne with zero=1 → pcen=0. Both give instret +1.
- lui (op=001111) → IEX shows alucont=001, shiftl16=1, signext=0. IWB shows regwrite=1, regdst=0.
- op=111111, then R-type with funct=000111 → each gives DECODE with illegal=1 for one cycle, then FETCH. No regwrite or memwrite, instret unchanged.
